// File: rtl/desc_mem_pkg.sv
// Shared types and constants for the descriptor RAM arbiter.
package desc_mem_pkg;

    localparam int unsigned DESC_ADDR_W = 14;
    localparam int unsigned DESC_DATA_W = 32;
    localparam int unsigned DESC_BE_W   = DESC_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic valid;
        logic master;
    } rd_tag_t;

endpackage

// File: rtl/desc_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, master} alongside the RAM read latency.
module desc_rd_tag_pipe
    import desc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/descriptor_mem_arbiter.sv
// Two-master Avalon-MM arbiter for the single-port descriptor RAM:
// round-robin (or fixed) grant, lock for atomic RMW, pipelined read returns.
module descriptor_mem_arbiter
    import desc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DESC_ADDR_W,
    parameter int unsigned DATA_W     = DESC_DATA_W,
    parameter int unsigned BE_W       = DATA_W / 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    lock_state_e lock_q, lock_d;
    logic        ready_q;
    logic        last_grant_q, last_grant_d;

    logic    req0, req1;
    logic    gnt0, gnt1;
    logic    rd_accept;
    rd_tag_t tag_in, tag_out;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // A lock owner is the only candidate; otherwise the master that did not
    // win last time goes first when both ask.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (ready_q) begin
            unique case (lock_q)
                LOCK0: gnt0 = req0;
                LOCK1: gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        if (FIXED_PRIO || last_grant_q) begin
                            gnt0 = 1'b1;
                        end else begin
                            gnt1 = 1'b1;
                        end
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);

    // Write beats read when both strobes are raised, so such a beat is no read.
    assign rd_accept = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);

    always_comb begin
        tag_in        = '0;
        tag_in.valid  = rd_accept;
        tag_in.master = gnt1;
    end

    desc_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    assign m0_readdatavalid = tag_out.valid & ~tag_out.master;
    assign m1_readdatavalid = tag_out.valid &  tag_out.master;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
        end
    end

    always_comb begin
        lock_d = lock_q;
        unique case (lock_q)
            IDLE: begin
                if (gnt0 && m0_lock) begin
                    lock_d = LOCK0;
                end else if (gnt1 && m1_lock) begin
                    lock_d = LOCK1;
                end
            end
            LOCK0: begin
                if (!m0_lock && (gnt0 || !req0)) begin
                    lock_d = IDLE;
                end
            end
            LOCK1: begin
                if (!m1_lock && (gnt1 || !req1)) begin
                    lock_d = IDLE;
                end
            end
            default: lock_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_q       <= IDLE;
        end else begin
            ready_q      <= 1'b1;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
        end
    end

endmodule

// File: tb/tb_descriptor_mem_arbiter.sv
// Randomised + directed bench for descriptor_mem_arbiter against a queue-based model.
module tb_descriptor_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] d_a  [2];
    logic [BW-1:0] d_be [2];
    logic [DW-1:0] d_wd [2];
    logic          d_rd [2];
    logic          d_wr [2];
    logic          d_lk [2];

    logic          w0, w1, rdv0, rdv1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write;
    logic [DW-1:0] mem_writedata, mem_readdata;

    logic          fw0, fw1, frdv0, frdv1;
    logic [DW-1:0] frdata0, frdata1, f_wd;
    logic [AW-1:0] f_addr;
    logic [BW-1:0] f_be;
    logic          f_cs, f_we;

    descriptor_mem_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(d_a[0]), .m0_byteenable(d_be[0]), .m0_read(d_rd[0]), .m0_write(d_wr[0]),
        .m0_writedata(d_wd[0]), .m0_lock(d_lk[0]), .m0_waitrequest(w0), .m0_readdata(rdata0),
        .m0_readdatavalid(rdv0),
        .m1_address(d_a[1]), .m1_byteenable(d_be[1]), .m1_read(d_rd[1]), .m1_write(d_wr[1]),
        .m1_writedata(d_wd[1]), .m1_lock(d_lk[1]), .m1_waitrequest(w1), .m1_readdata(rdata1),
        .m1_readdatavalid(rdv1),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    descriptor_mem_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_address(d_a[0]), .m0_byteenable(d_be[0]), .m0_read(d_rd[0]), .m0_write(d_wr[0]),
        .m0_writedata(d_wd[0]), .m0_lock(d_lk[0]), .m0_waitrequest(fw0), .m0_readdata(frdata0),
        .m0_readdatavalid(frdv0),
        .m1_address(d_a[1]), .m1_byteenable(d_be[1]), .m1_read(d_rd[1]), .m1_write(d_wr[1]),
        .m1_writedata(d_wd[1]), .m1_lock(d_lk[1]), .m1_waitrequest(fw1), .m1_readdata(frdata1),
        .m1_readdatavalid(frdv1),
        .mem_address(f_addr), .mem_byteenable(f_be), .mem_chipselect(f_cs),
        .mem_write(f_we), .mem_writedata(f_wd), .mem_readdata(32'h0)
    );

    // RAM behind the arbiter: registered read, read-before-write.
    logic [DW-1:0] ram [16384];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            mem_readdata <= ram[mem_address];
            if (mem_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { bit rd; bit wr; bit lk; logic [AW-1:0] a; logic [BW-1:0] be; logic [DW-1:0] d; } req_t;
    typedef struct { bit m; logic [DW-1:0] d; int due; } ret_t;
    typedef struct { int cyc; bit m; bit wr; } acc_t;

    req_t q0[$];
    req_t q1[$];
    ret_t pend[$];
    acc_t acc_log[$];

    bit  active [2];
    bit  acc    [2];
    int  cyc = 0;
    int  rdv_cnt [2];
    logic [DW-1:0] last_rdata [2];
    int  last_rdv_cyc [2];

    // Model state: who may be granted, whose turn it is, expected memory contents.
    bit  m_ready = 0;
    bit  m_last  = 1;
    int  m_lock  = 0;   // 0 none, 1 held by m0, 2 held by m1
    logic [DW-1:0] mmem [16384];

    function automatic req_t mk(bit rd, bit wr, bit lk, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] d);
        req_t r;
        r.rd = rd; r.wr = wr; r.lk = lk; r.a = a; r.be = be; r.d = d;
        return r;
    endfunction

    task automatic apply(input int n, input req_t r);
        d_rd[n] = r.rd; d_wr[n] = r.wr; d_lk[n] = r.lk;
        d_a[n] = r.a; d_be[n] = r.be; d_wd[n] = r.d;
        active[n] = r.rd | r.wr;
    endtask

    // Masters: hold a request until accepted, then take the next queued one.
    always @(posedge clk) begin : drv
        req_t r;
        #1;
        for (int n = 0; n < 2; n++) begin
            if (!active[n] || acc[n]) begin
                active[n] = 0; d_rd[n] = 0; d_wr[n] = 0; d_lk[n] = 0;
                if (n == 0 && q0.size() > 0) begin
                    r = q0.pop_front(); apply(0, r);
                end else if (n == 1 && q1.size() > 0) begin
                    r = q1.pop_front(); apply(1, r);
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int   g;
        bit   r0, r1, wr_g, lk_g;
        ret_t p;
        acc_t e;
        cyc++;
        if (!reset_n) begin
            chk("rst_m0_waitrequest", w0, 1);
            chk("rst_m1_waitrequest", w1, 1);
            chk("rst_chipselect", mem_chipselect, 0);
            chk("rst_rdv", {rdv0, rdv1}, 0);
            m_ready = 0; m_last = 1; m_lock = 0;
            pend.delete();
            acc[0] = 0; acc[1] = 0;
        end else begin
            r0 = d_rd[0] | d_wr[0];
            r1 = d_rd[1] | d_wr[1];
            g = -1;
            if (m_ready) begin
                if (m_lock == 1) begin
                    if (r0) g = 0;
                end else if (m_lock == 2) begin
                    if (r1) g = 1;
                end else if (r0 && r1) g = (m_last == 0) ? 1 : 0;
                else if (r0) g = 0;
                else if (r1) g = 1;
            end
            chk("m0_waitrequest", w0, g != 0);
            chk("m1_waitrequest", w1, g != 1);
            chk("mem_chipselect", mem_chipselect, g >= 0);
            if (g >= 0) begin
                wr_g = d_wr[g];
                lk_g = d_lk[g];
                chk("mem_address", mem_address, d_a[g]);
                chk("mem_write", mem_write, wr_g);
                chk("mem_byteenable", mem_byteenable, d_be[g]);
                if (wr_g) chk("mem_writedata", mem_writedata, d_wd[g]);
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                chk("m0_readdatavalid", rdv0, p.m == 0);
                chk("m1_readdatavalid", rdv1, p.m == 1);
                chk("readdata", p.m ? rdata1 : rdata0, p.d);
            end else begin
                chk("idle_readdatavalid", {rdv0, rdv1}, 0);
            end
            if (rdv0) begin rdv_cnt[0]++; last_rdata[0] = rdata0; last_rdv_cyc[0] = cyc; end
            if (rdv1) begin rdv_cnt[1]++; last_rdata[1] = rdata1; last_rdv_cyc[1] = cyc; end
            acc[0] = !w0;
            acc[1] = !w1;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin e.cyc = cyc; e.m = n[0]; e.wr = d_wr[n]; acc_log.push_back(e); end
            end
            if (g >= 0) begin
                m_last = g[0];
                if (wr_g) begin
                    for (int b = 0; b < BW; b++)
                        if (d_be[g][b]) mmem[d_a[g]][8*b +: 8] = d_wd[g][8*b +: 8];
                end else begin
                    p.m = g[0]; p.d = mmem[d_a[g]]; p.due = cyc + 1;
                    pend.push_back(p);
                end
                if (m_lock == 0 && lk_g) m_lock = g + 1;
                else if (m_lock == g + 1 && !lk_g) m_lock = 0;
            end
            if (m_lock == 1 && !r0 && !d_lk[0]) m_lock = 0;
            if (m_lock == 2 && !r1 && !d_lk[1]) m_lock = 0;
            m_ready = 1;
        end
    end

    task automatic drain(input string nm);
        int k;
        for (k = 0; k < 400; k++) begin
            if (q0.size() == 0 && q1.size() == 0 && !active[0] && !active[1] && pend.size() == 0) break;
            @(negedge clk);
        end
        chk({nm, "_drain_timeout"}, k >= 400, 0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int k;
        for (int i = 0; i < 16384; i++) begin ram[i] = '0; mmem[i] = '0; end
        for (int n = 0; n < 2; n++) begin
            d_a[n] = '0; d_be[n] = '0; d_wd[n] = '0; d_rd[n] = 0; d_wr[n] = 0; d_lk[n] = 0;
        end
        repeat (3) @(posedge clk);

        // Reset release with m0 already requesting
        q0.push_back(mk(1, 0, 0, 14'h0020, 4'hf, 0));
        @(posedge clk);
        #3 reset_n = 1;
        @(negedge clk);
        chk("t1_not_ready_wait", w0, 1);
        chk("t1_not_ready_cs", mem_chipselect, 0);
        chk("t1_rdv", {rdv0, rdv1}, 0);
        @(negedge clk);
        chk("t1_first_accept", w0, 0);
        drain("t1");

        // Partial write then read-back
        acc_log.delete();
        q0.push_back(mk(0, 1, 0, 14'h0010, 4'b0011, 32'hDEADBEEF));
        q0.push_back(mk(1, 0, 0, 14'h0010, 4'hf, 0));
        drain("t2");
        chk("t2_accepts", acc_log.size(), 2);
        chk("t2_readdata", last_rdata[0], 32'h0000BEEF);
        if (acc_log.size() == 2) chk("t2_latency", last_rdv_cyc[0] - acc_log[1].cyc, 1);

        // Both masters reading back-to-back
        acc_log.delete();
        rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1, 0, 0, 14'(16 + i), 4'hf, 0));
            q1.push_back(mk(1, 0, 0, 14'(16 + i), 4'hf, 0));
        end
        drain("t3");
        chk("t3_accepts", acc_log.size(), 8);
        ok = (acc_log.size() == 8);
        for (int i = 1; i < acc_log.size(); i++)
            if (acc_log[i].m == acc_log[i-1].m || acc_log[i].cyc != acc_log[i-1].cyc + 1) ok = 0;
        chk("t3_alternate", ok, 1);
        chk("t3_m0_returns", rdv_cnt[0], 4);
        chk("t3_m1_returns", rdv_cnt[1], 4);

        // m1 locked read-modify-write while m0 keeps asking
        acc_log.delete();
        q1.push_back(mk(1, 0, 1, 14'h0100, 4'hf, 0));
        q1.push_back(mk(0, 1, 0, 14'h0100, 4'hf, 32'h12345678));
        q0.push_back(mk(0, 0, 0, 0, 0, 0));
        q0.push_back(mk(1, 0, 0, 14'h0020, 4'hf, 0));
        q0.push_back(mk(1, 0, 0, 14'h0021, 4'hf, 0));
        drain("t4");
        chk("t4_accepts", acc_log.size(), 4);
        ok = (acc_log.size() == 4);
        if (ok) begin
            ok = acc_log[0].m == 1 && !acc_log[0].wr && acc_log[1].m == 1 && acc_log[1].wr &&
                 acc_log[2].m == 0 && acc_log[3].m == 0 &&
                 acc_log[1].cyc == acc_log[0].cyc + 1 && acc_log[2].cyc == acc_log[1].cyc + 1;
        end
        chk("t4_lock_order", ok, 1);

        // Reset with a read in flight and m1 holding the lock
        acc_log.delete();
        q1.push_back(mk(1, 0, 1, 14'h0030, 4'hf, 0));
        q1.push_back(mk(1, 0, 1, 14'h0031, 4'hf, 0));
        for (k = 0; k < 50 && acc_log.size() == 0; k++) begin @(negedge clk); #1; end
        chk("t5_accept_timeout", k >= 50, 0);
        @(posedge clk);
        #2 reset_n = 0;
        @(negedge clk);
        chk("t5_no_rdv", rdv1, 0);
        q0.push_back(mk(1, 0, 0, 14'h0022, 4'hf, 0));
        repeat (2) @(posedge clk);
        #3 reset_n = 1;
        acc_log.delete();
        drain("t5");
        chk("t5_accepts", acc_log.size(), 2);
        if (acc_log.size() == 2) chk("t5_first_is_m0", {acc_log[0].m, acc_log[1].m}, 2'b01);

        // Fixed-priority instance with both masters asking every cycle
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk(1, 0, 0, 14'(32 + i), 4'hf, 0));
            q1.push_back(mk(1, 0, 0, 14'(48 + i), 4'hf, 0));
        end
        @(posedge clk);
        repeat (6) begin
            @(negedge clk);
            chk("t6_fp_m0_wait", fw0, 0);
            chk("t6_fp_m1_wait", fw1, 1);
            chk("t6_fp_addr", f_addr, d_a[0]);
        end
        drain("t6");

        // Random traffic, small address window for collisions
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                req_t r;
                int kind;
                if ((n == 0 ? q0.size() : q1.size()) < 2) begin
                    kind = $urandom_range(0, 15);
                    r = mk(kind >= 4 && kind < 10, kind >= 10, $urandom_range(0, 3) == 0,
                           14'(32 + $urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom);
                    if (kind == 15) r.rd = 1;
                    if (kind < 4) r.lk = 0;
                    if (n == 0) q0.push_back(r); else q1.push_back(r);
                end
            end
        end
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
